// File: rtl/lockstep_compare.sv
// lockstep_compare: pairs in-order result words from two redundant cores per channel and flags mismatches/timeouts
// Ports: clk, reset_n (async, active-low), clear (sync wipe of all channel state);
// a_/b_ data/valid/ready push streams per channel (ready = side FIFO not full);
// match/mismatch/timeout pulses, sticky flags, saturating mismatch_count per channel;
// any_error is the registered OR of every sticky flag.
module lockstep_compare #(
    parameter int WIDTH    = 512,
    parameter int CHANNELS = 3,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic [CHANNELS*WIDTH-1:0] a_data,
    input  logic [CHANNELS-1:0]       a_valid,
    output logic [CHANNELS-1:0]       a_ready,
    input  logic [CHANNELS*WIDTH-1:0] b_data,
    input  logic [CHANNELS-1:0]       b_valid,
    output logic [CHANNELS-1:0]       b_ready,
    output logic [CHANNELS-1:0]       match_pulse,
    output logic [CHANNELS-1:0]       mismatch_pulse,
    output logic [CHANNELS-1:0]       timeout_pulse,
    output logic [CHANNELS-1:0]       mismatch_sticky,
    output logic [CHANNELS-1:0]       timeout_sticky,
    output logic [CHANNELS*CNT_W-1:0] mismatch_count,
    output logic                      any_error
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    logic [CHANNELS-1:0] err;
    genvar c;
    for (c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] a_mem [DEPTH];
        logic [WIDTH-1:0] b_mem [DEPTH];
        logic [AW:0] a_wp, a_rp, b_wp, b_rp;
        logic [TW-1:0] timer;
        logic [CNT_W-1:0] cnt;
        logic a_empty, b_empty, a_full, b_full, a_push, b_push, pair, lone, fire, eq;
        logic mp, mmp, tp, ms, ts;
        // Pointers carry an extra wrap bit so full and empty are distinguishable.
        assign a_empty = a_wp == a_rp;
        assign b_empty = b_wp == b_rp;
        assign a_full  = a_wp == {~a_rp[AW], a_rp[AW-1:0]};
        assign b_full  = b_wp == {~b_rp[AW], b_rp[AW-1:0]};
        assign a_push  = a_valid[c] && !a_full && !clear;
        assign b_push  = b_valid[c] && !b_full && !clear;
        assign eq      = a_mem[a_rp[AW-1:0]] == b_mem[b_rp[AW-1:0]];
        assign pair    = !a_empty && !b_empty;
        assign lone    = a_empty ^ b_empty;
        assign fire    = lone && timer == TW'(TIMEOUT - 1);
        always_ff @(posedge clk) begin
            if (a_push) a_mem[a_wp[AW-1:0]] <= a_data[c*WIDTH +: WIDTH];
            if (b_push) b_mem[b_wp[AW-1:0]] <= b_data[c*WIDTH +: WIDTH];
        end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                {a_wp, a_rp, b_wp, b_rp} <= '0;
                {timer, cnt, mp, mmp, tp, ms, ts} <= '0;
            end else if (clear) begin
                {a_wp, a_rp, b_wp, b_rp} <= '0;
                {timer, cnt, mp, mmp, tp, ms, ts} <= '0;
            end else begin
                a_wp  <= a_wp + (AW+1)'(a_push);
                b_wp  <= b_wp + (AW+1)'(b_push);
                // A flush jumps the read pointer to the pre-edge write pointer,
                // so a word pushed in the flush cycle survives.
                a_rp  <= (fire && !a_empty) ? a_wp : a_rp + (AW+1)'(pair);
                b_rp  <= (fire && !b_empty) ? b_wp : b_rp + (AW+1)'(pair);
                timer <= (lone && !fire) ? timer + 1'b1 : '0;
                mp    <= pair && eq;
                mmp   <= pair && !eq;
                tp    <= fire;
                ms    <= ms || (pair && !eq);
                ts    <= ts || fire;
                cnt   <= cnt + CNT_W'(pair && !eq && cnt != '1);
            end
        end
        assign a_ready[c]         = !a_full;
        assign b_ready[c]         = !b_full;
        assign match_pulse[c]     = mp;
        assign mismatch_pulse[c]  = mmp;
        assign timeout_pulse[c]   = tp;
        assign mismatch_sticky[c] = ms;
        assign timeout_sticky[c]  = ts;
        assign mismatch_count[c*CNT_W +: CNT_W] = cnt;
        assign err[c] = ms || ts;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) any_error <= 1'b0;
        else any_error <= !clear && |err;
    end
endmodule

// File: tb/tb_lockstep_compare.sv
// tb_lockstep_compare: table, directed and randomized checks of lockstep_compare against a queue-based model
module tb_lockstep_compare;
    localparam int W = 8, C = 2, D = 4, T = 16, CW = 4;
    logic clk = 0, reset_n = 0, clear = 0;
    logic [C*W-1:0] a_data = '0, b_data = '0;
    logic [C-1:0] a_valid = '0, b_valid = '0;
    logic [C-1:0] a_ready, b_ready, match_pulse, mismatch_pulse, timeout_pulse;
    logic [C-1:0] mismatch_sticky, timeout_sticky;
    logic [C*CW-1:0] mismatch_count;
    logic any_error;

    lockstep_compare #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .match_pulse(match_pulse), .mismatch_pulse(mismatch_pulse), .timeout_pulse(timeout_pulse),
        .mismatch_sticky(mismatch_sticky), .timeout_sticky(timeout_sticky),
        .mismatch_count(mismatch_count), .any_error(any_error)
    );

    always #5 clk = ~clk;

    int pass_n = 0, total_n = 0;

    typedef logic [W-1:0] wq_t[$];
    wq_t qa[C], qb[C];
    int tmr[C], cnt[C];
    logic [C-1:0] e_mp, e_mmp, e_tp, e_ms, e_ts;
    logic e_any;

    typedef struct {
        logic av, bv;
        logic [W-1:0] ad, bd;
        logic [C-1:0] mp, mmp;
        int cnt1;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(string name, int act, int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int c = 0; c < C; c++) begin
            qa[c].delete();
            qb[c].delete();
            tmr[c] = 0;
            cnt[c] = 0;
        end
        {e_mp, e_mmp, e_tp, e_ms, e_ts} = '0;
        e_any = 0;
    endfunction

    // Advance the model over one clock edge using the currently driven inputs.
    function automatic void model_step();
        if (!reset_n || clear) begin
            model_reset();
            return;
        end
        e_any = |(e_ms | e_ts);
        for (int c = 0; c < C; c++) begin
            bit pa, pb, pair, lone, fire, eq;
            pa   = a_valid[c] && qa[c].size() < D;
            pb   = b_valid[c] && qb[c].size() < D;
            pair = qa[c].size() > 0 && qb[c].size() > 0;
            lone = (qa[c].size() == 0) != (qb[c].size() == 0);
            fire = lone && tmr[c] == T - 1;
            e_mp[c] = 0;
            e_mmp[c] = 0;
            if (pair) begin
                eq = qa[c][0] == qb[c][0];
                void'(qa[c].pop_front());
                void'(qb[c].pop_front());
                e_mp[c] = eq;
                e_mmp[c] = !eq;
                if (!eq) begin
                    e_ms[c] = 1;
                    if (cnt[c] < 2**CW - 1) cnt[c]++;
                end
            end
            e_tp[c] = fire;
            if (fire) begin
                e_ts[c] = 1;
                qa[c].delete();
                qb[c].delete();
            end
            tmr[c] = (lone && !fire) ? tmr[c] + 1 : 0;
            if (pa) qa[c].push_back(a_data[c*W +: W]);
            if (pb) qb[c].push_back(b_data[c*W +: W]);
        end
    endfunction

    task automatic check_all();
        logic [C-1:0] er, br;
        for (int c = 0; c < C; c++) begin
            er[c] = qa[c].size() < D;
            br[c] = qb[c].size() < D;
            chk("mismatch_count", int'(mismatch_count[c*CW +: CW]), cnt[c]);
        end
        chk("a_ready", int'(a_ready), int'(er));
        chk("b_ready", int'(b_ready), int'(br));
        chk("match_pulse", int'(match_pulse), int'(e_mp));
        chk("mismatch_pulse", int'(mismatch_pulse), int'(e_mmp));
        chk("timeout_pulse", int'(timeout_pulse), int'(e_tp));
        chk("mismatch_sticky", int'(mismatch_sticky), int'(e_ms));
        chk("timeout_sticky", int'(timeout_sticky), int'(e_ts));
        chk("any_error", int'(any_error), int'(e_any));
    endtask

    task automatic tick();
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nm;
        int ra[C], rb[C];
        tbl[0] = '{1, 1, 8'h01, 8'h01, 2'b00, 2'b00, 0};
        tbl[1] = '{1, 1, 8'h02, 8'hFF, 2'b00, 2'b00, 0};
        tbl[2] = '{1, 1, 8'h03, 8'h03, 2'b10, 2'b00, 0};
        tbl[3] = '{0, 0, 8'h00, 8'h00, 2'b00, 2'b10, 1};
        tbl[4] = '{0, 0, 8'h00, 8'h00, 2'b10, 2'b00, 1};
        tbl[5] = '{0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 1};
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_ready", int'({a_ready, b_ready}), 4'hF);
        tick();
        reset_n = 1;
        tick();

        // single matching pair on ch0
        a_valid = 2'b01; b_valid = 2'b01; a_data = 16'h005A; b_data = 16'h005A;
        tick();
        a_valid = 0; b_valid = 0;
        tick();
        chk("t1_match_c2", int'(match_pulse[0]), 1);
        tick();
        chk("t1_match_c3", int'(match_pulse[0]), 0);
        chk("t1_count", int'(mismatch_count), 0);
        chk("t1_any_error", int'(any_error), 0);

        // ch1 sequence from table
        for (int i = 0; i < 6; i++) begin
            a_valid = {tbl[i].av, 1'b0};
            b_valid = {tbl[i].bv, 1'b0};
            a_data = {tbl[i].ad, 8'h00};
            b_data = {tbl[i].bd, 8'h00};
            chk("tbl_match", int'(match_pulse), int'(tbl[i].mp));
            chk("tbl_mismatch", int'(mismatch_pulse), int'(tbl[i].mmp));
            chk("tbl_count1", int'(mismatch_count[7:4]), tbl[i].cnt1);
            chk("tbl_count0", int'(mismatch_count[3:0]), 0);
            tick();
        end
        a_valid = 0; b_valid = 0;
        chk("tbl_sticky", int'(mismatch_sticky), 2'b10);

        // fill ch0 A FIFO, hold a fifth word, then drain with equal B words
        for (int i = 0; i < 4; i++) begin
            a_valid = 2'b01; a_data = 16'(i + 1);
            tick();
        end
        chk("full_ready", int'(a_ready[0]), 0);
        a_data = 16'h0055;
        tick();
        chk("held_ready", int'(a_ready[0]), 0);
        a_valid = 0;
        nm = 0;
        for (int i = 0; i < 10; i++) begin
            b_valid = i < 4 ? 2'b01 : 2'b00;
            b_data = 16'(i + 1);
            nm += int'(match_pulse[0]);
            tick();
        end
        chk("drain_matches", nm, 4);
        chk("drain_ready", int'(a_ready[0]), 1);

        // lone A word times out
        clear = 1;
        tick();
        clear = 0;
        a_valid = 2'b01; a_data = 16'h0033;
        tick();
        a_valid = 0;
        for (int k = 1; k <= 18; k++) begin
            if (k == 16) chk("to_pulse_c16", int'(timeout_pulse[0]), 0);
            if (k == 17) begin
                chk("to_pulse_c17", int'(timeout_pulse[0]), 1);
                chk("to_sticky_c17", int'(timeout_sticky[0]), 1);
                chk("to_any_c17", int'(any_error), 0);
            end
            if (k == 18) chk("to_any_c18", int'(any_error), 1);
            tick();
        end

        // saturate ch1 mismatch counter, then clear
        for (int i = 0; i < 20; i++) begin
            a_valid = 2'b10; b_valid = 2'b10;
            a_data = {8'(i), 8'h00};
            b_data = {~8'(i), 8'h00};
            tick();
        end
        a_valid = 0; b_valid = 0;
        repeat (3) tick();
        chk("sat_count", int'(mismatch_count[7:4]), 15);
        clear = 1;
        tick();
        clear = 0;
        chk("clr_count", int'(mismatch_count), 0);
        chk("clr_sticky", int'({mismatch_sticky, timeout_sticky}), 0);
        tick();

        // reset while ch0 holds two unpaired A words
        a_valid = 2'b01; a_data = 16'h00AA;
        tick();
        a_data = 16'h00BB;
        tick();
        a_valid = 0;
        reset_n = 0;
        #1;
        model_reset();
        chk("rst_outputs", int'({match_pulse, mismatch_pulse, timeout_pulse, mismatch_sticky,
                                 timeout_sticky, mismatch_count, any_error}), 0);
        chk("rst_ready", int'({a_ready, b_ready}), 4'hF);
        tick();
        reset_n = 1;
        tick();
        a_valid = 2'b01; b_valid = 2'b01; a_data = 16'h0011; b_data = 16'h0011;
        tick();
        a_valid = 0; b_valid = 0;
        tick();
        chk("post_rst_match", int'(match_pulse[0]), 1);
        chk("post_rst_mismatch", int'(mismatch_pulse[0]), 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0)
                for (int c = 0; c < C; c++) begin
                    ra[c] = $urandom_range(0, 4);
                    rb[c] = $urandom_range(0, 4);
                end
            for (int c = 0; c < C; c++) begin
                a_valid[c] = $urandom_range(0, 3) < ra[c];
                b_valid[c] = $urandom_range(0, 3) < rb[c];
                a_data[c*W +: W] = 8'($urandom_range(0, 3));
                b_data[c*W +: W] = 8'($urandom_range(0, 3));
            end
            clear = $urandom_range(0, 299) == 0;
            tick();
        end
        clear = 0; a_valid = 0; b_valid = 0;
        tick();

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
